// File: rtl/exc_ctrl.sv
// exc_ctrl: exception arbitration and pipeline-control sequencer for the
// five-stage MIPS core.
//
// Each cycle it looks at the exception flags of the instruction in MEM and at
// the synchronized external interrupts. It checks them against CP0
// Status/Cause, forwarding any pending CP0 write from MEM/WB first. It then
// drives the CP0 exception inputs and the pipeline stall, flush and redirect
// controls.
//
// Ports
//   clk                 core clock
//   rst                 synchronous, active-low reset
//   int_raw_i[5:0]      asynchronous external interrupt lines
//   exc_flags_i[4:0]    MEM flags {eret, ov, trap, ri, syscall}
//   mem_valid_i         MEM holds a real instruction (not a bubble)
//   mem_pc_i            PC of the MEM instruction
//   mem_in_delayslot_i  MEM instruction sits in a delay slot
//   cp0_status_i/cause_i/epc_i  current CP0 register values
//   cp0_we_i/waddr_i/wdata_i    pending CP0 write in MEM/WB
//   stallreq_id_i/ex_i  stall requests from ID and EX
//   int_o               synchronized interrupts, to CP0
//   excepttype_o        exception code, to CP0
//   cur_pc_o            MEM PC, to CP0
//   in_delayslot_o      MEM delay-slot flag, to CP0
//   stall_o[5:0]        stall vector {wb, mem, ex, id, if, pc}
//   flush_o             flush all pipeline registers
//   new_pc_o            redirect target, valid while flush_o=1
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_raw_i,
    input  logic [4:0]  exc_flags_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    output logic [5:0]  int_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] cur_pc_o,
    output logic        in_delayslot_o,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] npc_q, npc_d;
    logic [5:0]  sync1_q, sync2_q;

    logic [31:0] status_eff;
    logic [31:0] epc_eff;
    logic [7:0]  cause_ip;
    logic        int_pending;
    logic        accept;
    logic [31:0] code;
    logic        is_eret;
    logic [31:0] excepttype_run;
    logic [5:0]  stall_run;
    logic        flush_run;
    logic [31:0] new_pc_run;

    // Bits of the CP0 words this block does not look at.
    logic unused_bits;
    assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                           cp0_cause_i[31:10], cp0_cause_i[7:0]};

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            npc_q   <= 32'd0;
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            npc_q   <= npc_d;
            sync1_q <= int_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // CP0 forwarding and interrupt detection
    // ------------------------------------------------------------------
    always_comb begin
        status_eff = (cp0_we_i && cp0_waddr_i == ADDR_STATUS) ? cp0_wdata_i : cp0_status_i;
        epc_eff    = (cp0_we_i && cp0_waddr_i == ADDR_EPC)    ? cp0_wdata_i : cp0_epc_i;
        // Hardware IP bits come from the synchronizer, not from the Cause
        // register, so a freshly arrived interrupt is seen one cycle sooner.
        cause_ip[7:2] = sync2_q;
        cause_ip[1:0] = (cp0_we_i && cp0_waddr_i == ADDR_CAUSE) ? cp0_wdata_i[9:8]
                                                                : cp0_cause_i[9:8];
        // Interrupts need IE=1 and EXL=0.
        int_pending = ((cause_ip & status_eff[15:8]) != 8'd0)
                      && status_eff[0] && !status_eff[1];
    end

    // ------------------------------------------------------------------
    // Priority encoder: interrupt, syscall, ri, trap, ov, eret
    // ------------------------------------------------------------------
    always_comb begin
        code    = 32'd0;
        is_eret = 1'b0;
        if (int_pending)         code = 32'h1;
        else if (exc_flags_i[0]) code = 32'h8;
        else if (exc_flags_i[1]) code = 32'ha;
        else if (exc_flags_i[2]) code = 32'hd;
        else if (exc_flags_i[3]) code = 32'hc;
        else if (exc_flags_i[4]) begin
            code    = 32'he;
            is_eret = 1'b1;
        end
    end

    assign accept = (state_q == ST_RUN) && mem_valid_i
                    && (int_pending || (exc_flags_i != 5'd0));

    // ------------------------------------------------------------------
    // Next state and RUN/DRAIN outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        npc_d          = npc_q;
        excepttype_run = 32'd0;
        stall_run      = 6'd0;
        flush_run      = 1'b0;
        new_pc_run     = 32'd0;

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    // An exception overrides every stall request.
                    excepttype_run = code;
                    flush_run      = 1'b1;
                    new_pc_run     = is_eret ? epc_eff : EXC_VECTOR;
                    npc_d          = new_pc_run;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_DRAIN;
                        cnt_d   = 2'(FLUSH_CYCLES - 1);
                    end
                end else if (stallreq_ex_i) begin
                    stall_run = 6'b001111;
                end else if (stallreq_id_i) begin
                    stall_run = 6'b000111;
                end
            end
            ST_DRAIN: begin
                // Flags and interrupts arriving here are dropped, not queued.
                flush_run  = 1'b1;
                new_pc_run = npc_q;
                cnt_d      = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // While reset is asserted, every control output is held at zero.
    assign int_o          = rst ? sync2_q        : 6'd0;
    assign excepttype_o   = rst ? excepttype_run : 32'd0;
    assign stall_o        = rst ? stall_run      : 6'd0;
    assign flush_o        = rst ? flush_run      : 1'b0;
    assign new_pc_o       = rst ? new_pc_run     : 32'd0;
    assign cur_pc_o       = mem_pc_i;
    assign in_delayslot_o = mem_in_delayslot_i;

endmodule
